// File: rtl/barrel_shift_arbiter_amisha_if.sv
// barrel_shift_arbiter_amisha_if: request/result bundle for the shared rotator.
// Optional dir0/dir1 signals exist only with BARREL_SHIFT_ARB_ROTL_EN defined.
interface barrel_shift_arbiter_amisha_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req0_amisha;
    logic [WIDTH-1:0] a0_amisha;
    logic [AMT_W-1:0] amt0_amisha;
    logic             req1_amisha;
    logic [WIDTH-1:0] a1_amisha;
    logic [AMT_W-1:0] amt1_amisha;
    logic             gnt0_amisha;
    logic             gnt1_amisha;
    logic             busy_amisha;
    logic             valid_amisha;
    logic [WIDTH-1:0] y_amisha;
    logic             id_amisha;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
    logic             dir0_amisha;
    logic             dir1_amisha;
    modport master (
        output req0_amisha, a0_amisha, amt0_amisha, dir0_amisha,
        output req1_amisha, a1_amisha, amt1_amisha, dir1_amisha,
        input  gnt0_amisha, gnt1_amisha, busy_amisha, valid_amisha, y_amisha, id_amisha
    );
    modport slave (
        input  req0_amisha, a0_amisha, amt0_amisha, dir0_amisha,
        input  req1_amisha, a1_amisha, amt1_amisha, dir1_amisha,
        output gnt0_amisha, gnt1_amisha, busy_amisha, valid_amisha, y_amisha, id_amisha
    );
`else
    modport master (
        output req0_amisha, a0_amisha, amt0_amisha,
        output req1_amisha, a1_amisha, amt1_amisha,
        input  gnt0_amisha, gnt1_amisha, busy_amisha, valid_amisha, y_amisha, id_amisha
    );
    modport slave (
        input  req0_amisha, a0_amisha, amt0_amisha,
        input  req1_amisha, a1_amisha, amt1_amisha,
        output gnt0_amisha, gnt1_amisha, busy_amisha, valid_amisha, y_amisha, id_amisha
    );
`endif
endinterface

// File: rtl/barrel_shift_arbiter_amisha.sv
// barrel_shift_arbiter_amisha: round-robin shared rotator, one log-stage per clock.
// Define BARREL_SHIFT_ARB_ROTL_EN to add per-requester rotate-left direction.
module barrel_shift_arbiter_amisha #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic clk_amisha,
    input logic reset_amisha,
    barrel_shift_arbiter_amisha_if.slave bus
);
    localparam int SW = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [SW-1:0]    stage;
    logic [WIDTH-1:0] data, data_n;
    logic [AMT_W-1:0] amt;
    logic             last, owner, win, load, done, left;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
    logic             dir;
    assign left = dir;
`else
    assign left = 1'b0;
`endif
    // Rotate via a doubled word so the wrapped bits fall out of the shift naturally
    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d, input int k, input logic l);
        logic [2*WIDTH-1:0] q, r;
        q = {d, d};
        r = l ? q << k : q >> k;
        return l ? r[2*WIDTH-1:WIDTH] : r[WIDTH-1:0];
    endfunction
    assign win = (bus.req0_amisha & bus.req1_amisha) ? ~last : bus.req1_amisha;
    always_comb begin
        load    = (state == IDLE) && (bus.req0_amisha || bus.req1_amisha);
        done    = (state == SHIFT) && (stage == SW'(AMT_W - 1));
        state_n = load ? SHIFT : done ? IDLE : state;
        data_n  = amt[stage] ? rot(data, 1 << stage, left) : data;
    end
    always_ff @(posedge clk_amisha or posedge reset_amisha)
        if (reset_amisha) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            stage            <= '0;
            data             <= '0;
            amt              <= '0;
            owner            <= 1'b0;
            last             <= 1'b1;
            bus.gnt0_amisha  <= 1'b0;
            bus.gnt1_amisha  <= 1'b0;
            bus.busy_amisha  <= 1'b0;
            bus.valid_amisha <= 1'b0;
            bus.y_amisha     <= '0;
            bus.id_amisha    <= 1'b0;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
            dir              <= 1'b0;
`endif
        end else begin
            bus.gnt0_amisha  <= load & ~win;
            bus.gnt1_amisha  <= load & win;
            bus.busy_amisha  <= state_n == SHIFT;
            bus.valid_amisha <= done;
            if (load) begin
                data  <= win ? bus.a1_amisha : bus.a0_amisha;
                amt   <= win ? bus.amt1_amisha : bus.amt0_amisha;
                owner <= win;
                last  <= win;
                stage <= '0;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
                dir   <= win ? bus.dir1_amisha : bus.dir0_amisha;
`endif
            end else if (state == SHIFT) begin
                data  <= data_n;
                stage <= stage + 1'b1;
            end
            if (done) begin
                bus.y_amisha  <= data_n;
                bus.id_amisha <= owner;
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_arbiter_amisha.sv
// tb_barrel_shift_arbiter_amisha: vector table, corner sequences and random ops vs a rotate model.
// Direction vectors are included when BARREL_SHIFT_ARB_ROTL_EN is defined.
module tb_barrel_shift_arbiter_amisha;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   m_last = 1'b1;
    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [2:0] amt;
        bit         dir;
        logic [7:0] ey;
    } vec_t;
    vec_t tbl[$];
    barrel_shift_arbiter_amisha_if #(.WIDTH(8), .AMT_W(3)) bif ();
    barrel_shift_arbiter_amisha #(.WIDTH(8), .AMT_W(3)) dut (
        .clk_amisha(clk),
        .reset_amisha(reset),
        .bus(bif)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [7:0] ref_rot(input logic [7:0] a, input int k, input bit l);
        int v, s;
        s = l ? (8 - k) % 8 : k;
        v = a;
        v = ((v >> s) | (v << (8 - s))) & 8'hFF;
        return v[7:0];
    endfunction
    task automatic do_reset();
        bif.req0_amisha = 1'b0;
        bif.req1_amisha = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1;
    endtask
    // Waits for a grant, checks arbitration, then follows the op to its valid pulse
    task automatic serve(output logic [7:0] gy, output bit gid, output int wait_n);
        int t, lat, bc;
        bit w, ew, l;
        logic [7:0] ey;
        t = 0;
        gy = 8'h00;
        gid = 1'b0;
        while (!(bif.gnt0_amisha || bif.gnt1_amisha) && t < 20) begin
            @(negedge clk);
            t++;
        end
        wait_n = t;
        if (!(bif.gnt0_amisha || bif.gnt1_amisha)) begin
            chk(1'b0, "grant_timeout", t, 20);
            return;
        end
        chk(!(bif.gnt0_amisha && bif.gnt1_amisha), "gnt_onehot", {bif.gnt1_amisha, bif.gnt0_amisha}, 1);
        w = bif.gnt1_amisha;
        ew = (bif.req0_amisha && bif.req1_amisha) ? !m_last : bif.req1_amisha;
        chk(w == ew, "winner", w, ew);
        m_last = w;
        l = 1'b0;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
        l = w ? bif.dir1_amisha : bif.dir0_amisha;
`endif
        ey = ref_rot(w ? bif.a1_amisha : bif.a0_amisha, w ? int'(bif.amt1_amisha) : int'(bif.amt0_amisha), l);
        // Scramble the winner's operands: only the capture edge may matter
        if (w) begin
            bif.req1_amisha = 1'b0;
            bif.a1_amisha = 8'($urandom);
            bif.amt1_amisha = 3'($urandom);
        end else begin
            bif.req0_amisha = 1'b0;
            bif.a0_amisha = 8'($urandom);
            bif.amt0_amisha = 3'($urandom);
        end
        bc = 0;
        lat = 0;
        while (!bif.valid_amisha && lat < 10) begin
            bc += int'(bif.busy_amisha);
            @(negedge clk);
            lat++;
        end
        chk(lat == 3, "latency", lat, 3);
        chk(bc == 3, "busy_cycles", bc, 3);
        chk(bif.y_amisha == ey, "y", bif.y_amisha, ey);
        chk(bif.id_amisha == w, "id", bif.id_amisha, w);
        chk(!bif.busy_amisha && !bif.gnt0_amisha && !bif.gnt1_amisha, "idle_at_valid",
            {bif.busy_amisha, bif.gnt1_amisha, bif.gnt0_amisha}, 0);
        gy = bif.y_amisha;
        gid = bif.id_amisha;
    endtask
    initial begin
        logic [7:0] gy;
        bit gid, seen;
        int t;
        bif.req0_amisha = 1'b0;
        bif.req1_amisha = 1'b0;
        bif.a0_amisha = 8'h00;
        bif.a1_amisha = 8'h00;
        bif.amt0_amisha = 3'd0;
        bif.amt1_amisha = 3'd0;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
        bif.dir0_amisha = 1'b0;
        bif.dir1_amisha = 1'b0;
`endif
        tbl.push_back('{1'b0, 8'hBB, 3'd1, 1'b0, 8'hDD});
        tbl.push_back('{1'b1, 8'hBB, 3'd3, 1'b0, 8'h77});
        tbl.push_back('{1'b1, 8'hBB, 3'd2, 1'b0, 8'hEE});
        tbl.push_back('{1'b0, 8'hBB, 3'd0, 1'b0, 8'hBB});
        tbl.push_back('{1'b0, 8'hBB, 3'd4, 1'b0, 8'hBB});
        tbl.push_back('{1'b0, 8'h01, 3'd7, 1'b0, 8'h02});
        tbl.push_back('{1'b1, 8'h80, 3'd1, 1'b0, 8'h40});
        tbl.push_back('{1'b1, 8'hA5, 3'd5, 1'b0, 8'h2D});
`ifdef BARREL_SHIFT_ARB_ROTL_EN
        tbl.push_back('{1'b0, 8'hBB, 3'd1, 1'b1, 8'h77});
        tbl.push_back('{1'b0, 8'hBB, 3'd1, 1'b0, 8'hDD});
        tbl.push_back('{1'b1, 8'h81, 3'd3, 1'b1, 8'h0C});
`endif
        #12;
        chk(bif.gnt0_amisha == 1'b0, "rst_gnt0", bif.gnt0_amisha, 0);
        chk(bif.gnt1_amisha == 1'b0, "rst_gnt1", bif.gnt1_amisha, 0);
        chk(bif.busy_amisha == 1'b0, "rst_busy", bif.busy_amisha, 0);
        chk(bif.valid_amisha == 1'b0, "rst_valid", bif.valid_amisha, 0);
        chk(bif.y_amisha == 8'h00, "rst_y", bif.y_amisha, 0);
        chk(bif.id_amisha == 1'b0, "rst_id", bif.id_amisha, 0);
        @(negedge clk);
        reset = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].id) begin
                bif.a1_amisha = tbl[i].a;
                bif.amt1_amisha = tbl[i].amt;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
                bif.dir1_amisha = tbl[i].dir;
`endif
                bif.req1_amisha = 1'b1;
            end else begin
                bif.a0_amisha = tbl[i].a;
                bif.amt0_amisha = tbl[i].amt;
`ifdef BARREL_SHIFT_ARB_ROTL_EN
                bif.dir0_amisha = tbl[i].dir;
`endif
                bif.req0_amisha = 1'b1;
            end
            serve(gy, gid, t);
            chk(gy == tbl[i].ey, "tbl_y", gy, tbl[i].ey);
            chk(gid == tbl[i].id, "tbl_id", gid, tbl[i].id);
            @(negedge clk);
        end
        do_reset();
`ifdef BARREL_SHIFT_ARB_ROTL_EN
        bif.dir0_amisha = 1'b0;
        bif.dir1_amisha = 1'b0;
`endif
        bif.a0_amisha = 8'h01;
        bif.amt0_amisha = 3'd1;
        bif.a1_amisha = 8'h80;
        bif.amt1_amisha = 3'd1;
        bif.req0_amisha = 1'b1;
        bif.req1_amisha = 1'b1;
        serve(gy, gid, t);
        chk(gy == 8'h80 && gid == 1'b0, "pair_first", {gid, gy}, 9'h080);
        serve(gy, gid, t);
        chk(t == 1, "throughput", t, 1);
        chk(gy == 8'h40 && gid == 1'b1, "pair_second", {gid, gy}, 9'h140);
        @(negedge clk);
        chk(bif.valid_amisha == 1'b0, "valid_pulse", bif.valid_amisha, 0);
        bif.a0_amisha = 8'h01;
        bif.amt0_amisha = 3'd1;
        bif.a1_amisha = 8'h80;
        bif.amt1_amisha = 3'd1;
        bif.req0_amisha = 1'b1;
        bif.req1_amisha = 1'b1;
        serve(gy, gid, t);
        chk(gid == 1'b0, "pair_alternate", gid, 0);
        bif.req1_amisha = 1'b0;
        @(negedge clk);
        bif.a0_amisha = 8'hBB;
        bif.amt0_amisha = 3'd1;
        bif.req0_amisha = 1'b1;
        t = 0;
        while (!bif.gnt0_amisha && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(bif.gnt0_amisha == 1'b1, "midrst_grant", bif.gnt0_amisha, 1);
        bif.req0_amisha = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk(bif.busy_amisha == 1'b0 && bif.valid_amisha == 1'b0 && bif.y_amisha == 8'h00,
            "midrst_outputs", {bif.busy_amisha, bif.valid_amisha, bif.y_amisha}, 0);
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= bif.valid_amisha;
        end
        chk(!seen, "midrst_no_valid", seen, 0);
        bif.a0_amisha = 8'hBB;
        bif.amt0_amisha = 3'd2;
        bif.req0_amisha = 1'b1;
        serve(gy, gid, t);
        chk(gy == 8'hEE && gid == 1'b0, "midrst_recover", {gid, gy}, 9'h0EE);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bif.req0_amisha = 1'($urandom);
            bif.req1_amisha = bif.req0_amisha ? 1'($urandom) : 1'b1;
            bif.a0_amisha = 8'($urandom);
            bif.a1_amisha = 8'($urandom);
            bif.amt0_amisha = 3'($urandom);
            bif.amt1_amisha = 3'($urandom);
`ifdef BARREL_SHIFT_ARB_ROTL_EN
            bif.dir0_amisha = 1'($urandom);
            bif.dir1_amisha = 1'($urandom);
`endif
            serve(gy, gid, t);
            bif.req0_amisha = 1'b0;
            bif.req1_amisha = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
